// File: rtl/load_writeback_if.sv
// ============================================================================
// Module      : load_writeback_if
// Description : Result, RAM-read and register-file-write bundle for
//               load_writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface load_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_alu;
    logic        in_is_load;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        err;

    // Environment side: supplies results and RAM responses.
    modport master (
        output in_valid, in_rd, in_alu, in_is_load, in_size, in_unsigned,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_addr, A3, WD3, WE3, err
    );

    modport slave (
        input  in_valid, in_rd, in_alu, in_is_load, in_size, in_unsigned,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_addr, A3, WD3, WE3, err
    );
endinterface

`default_nettype wire

// File: rtl/load_writeback.sv
// ============================================================================
// Module      : load_writeback
// Description : Writeback stage: ALU results go straight to the register
//               file, loads fetch a RAM word, extract and extend the lane.
//               Optional macro SUBWORD_LOAD_EN enables byte/half loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_writeback #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    load_writeback_if.slave bus
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             we3_q, we3_d;
    logic             err_q, err_d;
    logic [4:0]       rd_q, rd_d;

    logic             w_accept;
    logic             w_misaligned;
    logic [31:0]      w_load_data;

`ifdef SUBWORD_LOAD_EN
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    always_comb begin
        w_misaligned = 1'b0;
        unique case (bus.in_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = bus.in_alu[0];
            default: w_misaligned = |bus.in_alu[1:0];
        endcase
    end

    // Little-endian lane select from the latched byte offset.
    always_comb begin
        w_byte      = 8'(bus.mem_rdata >> {off_q, 3'b000});
        w_half      = 16'(bus.mem_rdata >> {off_q[1], 4'b0000});
        w_load_data = bus.mem_rdata;
        unique case (size_q)
            2'b00:   w_load_data = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_data = bus.mem_rdata;
        endcase
    end
`else
    logic unused_cfg;
    assign unused_cfg   = ^{bus.in_size, bus.in_unsigned};
    assign w_misaligned = |bus.in_alu[1:0];
    assign w_load_data  = bus.mem_rdata;
`endif

    assign w_accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        we3_d      = 1'b0;
        err_d      = 1'b0;
        rd_d       = rd_q;
`ifdef SUBWORD_LOAD_EN
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
`endif
        unique case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (w_accept) begin
                    if (!bus.in_is_load) begin
                        state_d = WRITE;
                        a3_d    = bus.in_rd;
                        wd3_d   = bus.in_alu;
                        we3_d   = (bus.in_rd != 5'd0);
                    end else if (w_misaligned) begin
                        err_d   = 1'b1;
                    end else begin
                        state_d    = WAIT_MEM;
                        cnt_d      = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {bus.in_alu[31:2], 2'b00};
                        rd_d       = bus.in_rd;
`ifdef SUBWORD_LOAD_EN
                        off_d      = bus.in_alu[1:0];
                        size_d     = bus.in_size;
                        uns_d      = bus.in_unsigned;
`endif
                    end
                end
            end
            WAIT_MEM: begin
                // An ack in the final allowed cycle still completes the load.
                if (bus.mem_ack) begin
                    state_d   = WRITE;
                    mem_req_d = 1'b0;
                    a3_d      = rd_q;
                    wd3_d     = w_load_data;
                    we3_d     = (rd_q != 5'd0);
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d != WAIT_MEM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            a3_q       <= '0;
            wd3_q      <= '0;
            we3_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= '0;
`ifdef SUBWORD_LOAD_EN
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            we3_q      <= we3_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
`ifdef SUBWORD_LOAD_EN
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.A3       = a3_q;
    assign bus.WD3      = wd3_q;
    assign bus.WE3      = we3_q;
    assign bus.err      = err_q;

endmodule

`default_nettype wire

// File: doc/load_writeback.md
LOAD_WRITEBACK -- requirements
Module: load_writeback

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the maximum number of cycles spent waiting for mem_ack before a load is aborted.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream result valid.
REQ-005 in_ready  output  1  block can accept a result this cycle.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_alu  input  32  ALU result; load byte address when in_is_load=1.
REQ-008 in_is_load  input  1  1 = load, 0 = ALU writeback.
REQ-009 in_size  input  2  load size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 in_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-011 mem_req  output  1  RAM read request, held until acknowledged.
REQ-012 mem_addr  output  32  word-aligned RAM address.
REQ-013 mem_ack  input  1  RAM read data valid.
REQ-014 mem_rdata  input  32  RAM read data.
REQ-015 A3  output  5  register-file write index.
REQ-016 WD3  output  32  register-file write data.
REQ-017 WE3  output  1  register-file write enable, single-cycle pulse.
REQ-018 err  output  1  single-cycle pulse on misaligned load or timeout.

Function
REQ-019 The FSM SHALL have the states IDLE, WAIT_MEM and WRITE.
REQ-020 in_ready SHALL be 1 in IDLE and WRITE and 0 in WAIT_MEM; a transfer occurs when in_valid and in_ready are both 1.
REQ-021 An ALU transfer SHALL go to WRITE with A3=in_rd and WD3=in_alu registered, so WE3 asserts exactly 1 cycle after acceptance.
REQ-022 A load transfer SHALL go to WAIT_MEM and drive mem_req=1 and mem_addr={in_alu[31:2],2'b00} from the next cycle until the cycle mem_ack=1 is sampled.
REQ-023 A misaligned load (half with alu[0]=1, or word with alu[1:0]!=0) SHALL issue no mem_req, pulse err 1 cycle after acceptance, write nothing, and return to IDLE.
REQ-024 On mem_ack in WAIT_MEM, the block SHALL select the lane little-endian by alu[1:0] (byte: bits 8*alu[1:0]+7..; half: bits 16*alu[1]+15..), extend to 32 bits per in_unsigned, and go to WRITE.
REQ-025 The WAIT_MEM cycle counter SHALL start at 0; if it reaches MEM_TIMEOUT with no ack, the block SHALL drop mem_req, pulse err, write nothing, and go to IDLE.
REQ-026 If mem_ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack SHALL win and no err SHALL be raised.
REQ-027 mem_ack sampled outside WAIT_MEM SHALL be ignored.
REQ-028 WE3 SHALL be 1 only in WRITE and only when A3!=0; a write to register 0 is silently dropped.
REQ-029 A new transfer accepted in WRITE SHALL be processed back-to-back, giving one ALU writeback per cycle.

Reset
REQ-030 On rst, state SHALL be IDLE, the counter 0, and in_ready=1; mem_req, mem_addr, A3, WD3, WE3 and err SHALL all be 0 on the next edge.
REQ-031 A reset during WAIT_MEM SHALL abandon the load with no write and no err.

Configuration
REQ-032 With SUBWORD_LOAD_EN defined, byte and half loads SHALL behave as in REQ-023 and REQ-024.
REQ-033 Without SUBWORD_LOAD_EN, in_size and in_unsigned SHALL be ignored, every load SHALL be a word load, and alu[1:0]!=0 SHALL be treated as misaligned.

Verification
REQ-034 ALU transfer rd=5, alu=0x12345678 -> the next cycle shows WE3=1, A3=5, WD3=0x12345678.
REQ-035 Byte load, alu=0x103, signed, mem_rdata=0x80FFFFFF, ack after 3 cycles -> mem_addr=0x100, then WD3=0xFFFFFF80 with WE3 pulsed.
REQ-036 Half load, alu=0x101 -> no mem_req, err pulsed, WE3 stays 0.
REQ-037 Load with no ack -> after 15 WAIT_MEM cycles err=1, mem_req=0, IDLE; with ack on cycle 15 -> write occurs and err=0.
REQ-038 Back-to-back ALU transfers to rd=0 then rd=7 -> WE3 stays 0 for the first and is 1 for the second; in_ready stays 1 throughout.
